synaptic_current_gen: RTL and testbench



---
 rtl/synaptic_current_gen_if.sv | 23 ++
 rtl/synaptic_current_gen.sv | 103 ++++++++++
 tb/tb_synaptic_current_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/synaptic_current_gen_if.sv
// Bundle of the synaptic current generator's control, weight-write and current outputs.
// The master drives enable, spikes and weight writes. The slave returns current and sat.
interface synaptic_current_gen_if #(
   parameter int N_INPUTS = 4
);
   logic                en;
   logic [N_INPUTS-1:0] spike_in;
   logic                wr_en;
   logic [3:0]          wr_addr;
   logic [15:0]         wr_data;
   logic [31:0]         current_out;
   logic                sat;

   modport master (
      output en, spike_in, wr_en, wr_addr, wr_data,
      input  current_out, sat
   );

   modport slave (
      input  en, spike_in, wr_en, wr_addr, wr_data,
      output current_out, sat
   );
endinterface

// File: rtl/synaptic_current_gen.sv
// Presynaptic spike edges -> weighted, exponentially decaying, saturated Q16.16 current.
// Optional macro SYN_STICKY_SAT_EN: sat becomes sticky and is cleared by a write to address 4'hF.
module synaptic_current_gen_lane (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_en,
   input  logic        i_spike,
   input  logic        i_wr,
   input  logic [15:0] i_wdata,
   output logic [31:0] o_contrib
);
   logic [15:0] r_weight;
   logic        r_spike_q;
   logic        w_ev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_weight  <= '0;
         r_spike_q <= 1'b0;
      end else begin
         r_spike_q <= i_spike;
         if (i_wr) r_weight <= i_wdata;
      end
   end

   // The event uses the weight before this edge, so a write in the same cycle lands afterwards.
   assign w_ev      = i_en & i_spike & ~r_spike_q;
   assign o_contrib = w_ev ? {{8{r_weight[15]}}, r_weight, 8'h00} : 32'h0;
endmodule

module synaptic_current_gen #(
   parameter int N_INPUTS  = 4,
   parameter int TAU_SHIFT = 3,
   parameter int SAT_LIMIT = 6553600
) (
   input  logic                  clk,
   input  logic                  reset_n,
   synaptic_current_gen_if.slave bus
);
   localparam int SW = 32 + $clog2(N_INPUTS) + 1;
   localparam logic signed [SW-1:0] LIM_P = SW'(SAT_LIMIT);
   localparam logic signed [SW-1:0] LIM_N = -LIM_P;

   logic signed [31:0]           r_cur;
   logic                         r_sat;
   logic [N_INPUTS-1:0][31:0]    w_contrib;
   logic                         w_addr_ok;
   logic signed [SW-1:0]         w_sum;
   logic                         w_hi;
   logic                         w_lo;
   logic signed [31:0]           w_next;

`ifdef SYN_STICKY_SAT_EN
   logic w_clr;
   assign w_clr     = bus.wr_en && (bus.wr_addr == 4'hF);
   assign w_addr_ok = (bus.wr_addr != 4'hF);
`else
   assign w_addr_ok = 1'b1;
`endif

   genvar g;
   generate
      for (g = 0; g < N_INPUTS; g++) begin : g_lane
         synaptic_current_gen_lane u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_en      (bus.en),
            .i_spike   (bus.spike_in[g]),
            .i_wr      (bus.wr_en && w_addr_ok && (bus.wr_addr == 4'(g))),
            .i_wdata   (bus.wr_data),
            .o_contrib (w_contrib[g])
         );
      end
   endgenerate

   // Wide accumulator: N full-scale weights plus the decayed current cannot wrap.
   always_comb begin
      w_sum = SW'(r_cur) - SW'(r_cur >>> TAU_SHIFT);
      for (int i = 0; i < N_INPUTS; i++)
         w_sum = w_sum + SW'($signed(w_contrib[i]));
      w_hi   = (w_sum > LIM_P);
      w_lo   = (w_sum < LIM_N);
      w_next = w_hi ? LIM_P[31:0] : (w_lo ? LIM_N[31:0] : w_sum[31:0]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cur <= '0;
         r_sat <= 1'b0;
      end else begin
         if (bus.en) r_cur <= w_next;
`ifdef SYN_STICKY_SAT_EN
         if (bus.en && (w_hi || w_lo)) r_sat <= 1'b1;
         else if (w_clr)               r_sat <= 1'b0;
`else
         if (bus.en) r_sat <= w_hi | w_lo;
`endif
      end
   end

   assign bus.current_out = r_cur;
   assign bus.sat         = r_sat;
endmodule

// File: tb/tb_synaptic_current_gen.sv
// Self-checking bench for synaptic_current_gen.
// It combines directed test-plan cases with random traffic, checked against an arithmetic model.
module tb_synaptic_current_gen;
   localparam int N   = 4;
   localparam int TAU = 3;
   localparam int LIM = 6553600;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_fail;

   synaptic_current_gen_if #(.N_INPUTS(N)) bus ();

   synaptic_current_gen #(.N_INPUTS(N), .TAU_SHIFT(TAU), .SAT_LIMIT(LIM)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state, kept as plain integers.
   longint m_cur;
   bit     m_sat;
   longint m_w [N];
   bit     m_q [N];

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic longint cur_out();
      return longint'($signed(bus.current_out));
   endfunction

   task automatic model_clear();
      m_cur = 0;
      m_sat = 0;
      for (int i = 0; i < N; i++) begin
         m_w[i] = 0;
         m_q[i] = 0;
      end
   endtask

   // Called just after a falling edge: drives one cycle, advances the model, checks at the next fall.
   task automatic step(input bit en, input logic [N-1:0] sp, input bit we,
                       input logic [3:0] wa, input logic [15:0] wd);
      longint s;
      bit     sat_now;
      bus.en       = en;
      bus.spike_in = sp;
      bus.wr_en    = we;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      if (en) begin
         // Floor division by 2^TAU is the arithmetic right shift.
         s = m_cur - ((m_cur - ((m_cur % (1 << TAU) + (1 << TAU)) % (1 << TAU))) / (1 << TAU));
         for (int i = 0; i < N; i++)
            if (sp[i] && !m_q[i]) s += longint'($signed(16'(m_w[i]))) * 256;
         sat_now = 1'b1;
         if (s > LIM)       m_cur = LIM;
         else if (s < -LIM) m_cur = -LIM;
         else begin
            m_cur   = s;
            sat_now = 1'b0;
         end
`ifdef SYN_STICKY_SAT_EN
         if (sat_now) m_sat = 1'b1;
         else if (we && wa == 4'hF) m_sat = 1'b0;
`else
         m_sat = sat_now;
`endif
      end else begin
`ifdef SYN_STICKY_SAT_EN
         if (we && wa == 4'hF) m_sat = 1'b0;
`endif
      end
`ifdef SYN_STICKY_SAT_EN
      if (we && int'(wa) < N && wa != 4'hF) m_w[wa] = longint'($signed(wd));
`else
      if (we && int'(wa) < N) m_w[wa] = longint'($signed(wd));
`endif
      for (int i = 0; i < N; i++) m_q[i] = sp[i];
      @(negedge clk);
      chk("current_out", cur_out(), m_cur);
      chk("sat", longint'(bus.sat), longint'(m_sat));
   endtask

   // Reset asserted between clock edges must clear the outputs before the next edge.
   task automatic async_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_cur", cur_out(), 0);
      chk("async_rst_sat", longint'(bus.sat), 0);
      bus.en = 1'b0; bus.spike_in = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      reset_n = 1'b0;
      bus.en = 1'b0; bus.spike_in = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset_cur", cur_out(), 0);
      chk("reset_sat", longint'(bus.sat), 0);
      reset_n = 1'b1;

      // Idle with en high: current stays zero.
      for (int c = 0; c < 10; c++) step(1, '0, 0, 0, 0);
      chk("idle_cur", cur_out(), 0);

      // Single pulse, weight 10.0, followed by the decay sequence.
      step(1, '0, 1, 0, 16'h0A00);
      step(1, 4'b0001, 0, 0, 0);
      chk("pulse_w0", cur_out(), 655360);
      step(1, '0, 0, 0, 0);
      chk("decay1", cur_out(), 573440);
      step(1, '0, 0, 0, 0);
      chk("decay2", cur_out(), 501760);
      for (int c = 0; c < 60; c++) step(1, '0, 0, 0, 0);

      // A held level counts only once.
      async_reset();
      step(1, '0, 1, 1, 16'h0100);
      step(1, 4'b0010, 0, 0, 0);
      chk("held_once", cur_out(), 65536);
      for (int c = 0; c < 19; c++) step(1, 4'b0010, 0, 0, 0);

      // Positive then negative saturation.
      async_reset();
      for (int a = 0; a < N; a++) step(1, '0, 1, 4'(a), 16'h7FFF);
      step(1, 4'b1111, 0, 0, 0);
      chk("sat_pos_cur", cur_out(), 6553600);
      chk("sat_pos_flag", longint'(bus.sat), 1);
      step(1, '0, 0, 0, 0);
      for (int a = 0; a < N; a++) step(1, '0, 1, 4'(a), 16'h8000);
      step(1, 4'b1111, 0, 0, 0);
      chk("sat_neg_cur", cur_out(), -6553600);
      chk("sat_neg_flag", longint'(bus.sat), 1);
      step(1, '0, 1, 4'd9, 16'h7FFF);

      // A write on the same edge as the event uses the old weight.
      async_reset();
      step(1, '0, 1, 2, 16'h0200);
      step(1, 4'b0100, 1, 2, 16'h0500);
      chk("old_weight", cur_out(), 131072);
      step(1, '0, 0, 0, 0);
      step(1, 4'b0100, 0, 0, 0);
      chk("new_weight", cur_out(), 428032);

      // A rise while en is low is dropped and not replayed.
      async_reset();
      step(1, '0, 1, 3, 16'h0100);
      step(0, 4'b1000, 0, 0, 0);
      chk("en_low_hold", cur_out(), 0);
      step(1, 4'b1000, 0, 0, 0);
      chk("no_replay", cur_out(), 0);

      // Reset asserted during a decay.
      step(1, '0, 1, 0, 16'h1000);
      step(1, 4'b0001, 0, 0, 0);
      step(1, '0, 0, 0, 0);
      async_reset();

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         logic [15:0] wd;
         wd = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
         step($urandom_range(0, 9) != 0, N'($urandom), $urandom_range(0, 4) == 0,
              4'($urandom_range(0, 15)), wd);
         if (c == 200) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
